// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, function codes,
// FSM states, datapath control encodings and the decoded instruction class.
package mc_ctrl_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // FSM states; the numeric values are visible on the debug state port
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd7
    } state_t;

    // ALU operation select
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    // Immediate extension
    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    // Register write-back source
    localparam logic [1:0] M2R_ALU   = 2'b00;
    localparam logic [1:0] M2R_DOUT  = 2'b01;
    localparam logic [1:0] M2R_EXIMM = 2'b10;

    // Next-PC select
    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;

    // Instruction class, drives the FSM path taken after DECODE
    typedef enum logic [2:0] {
        CLS_ALU = 3'd0,
        CLS_LW  = 3'd1,
        CLS_SW  = 3'd2,
        CLS_BEQ = 3'd3,
        CLS_J   = 3'd4,
        CLS_ILL = 3'd5
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: classifies op/func and produces the
// static datapath controls that stay constant for the whole instruction.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output iclass_t    iclass,
    output logic       legal,
    output logic       alusrc,
    output logic       regdst,
    output logic [1:0] extop,
    output logic [1:0] memtoreg,
    output logic [2:0] aluctr
);

    // Opcode/function decode; anything not listed falls through as illegal
    always_comb begin
        iclass   = CLS_ILL;
        legal    = 1'b0;
        alusrc   = 1'b0;
        regdst   = 1'b0;
        extop    = EXT_ZERO;
        memtoreg = M2R_ALU;
        aluctr   = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                iclass = CLS_ALU;
                legal  = 1'b1;
                regdst = 1'b1;
                case (func)
                    FN_ADD:  aluctr = ALU_ADD;
                    FN_SUB:  aluctr = ALU_SUB;
                    FN_AND:  aluctr = ALU_AND;
                    FN_OR:   aluctr = ALU_OR;
                    FN_SLT:  aluctr = ALU_SLT;
                    default: begin
                        iclass = CLS_ILL;
                        legal  = 1'b0;
                        regdst = 1'b0;
                    end
                endcase
            end
            OP_ORI: begin
                iclass = CLS_ALU;
                legal  = 1'b1;
                alusrc = 1'b1;
                extop  = EXT_ZERO;
                aluctr = ALU_OR;
            end
            OP_ADDIU: begin
                iclass = CLS_ALU;
                legal  = 1'b1;
                alusrc = 1'b1;
                extop  = EXT_SIGN;
                aluctr = ALU_ADD;
            end
            OP_LUI: begin
                iclass   = CLS_ALU;
                legal    = 1'b1;
                alusrc   = 1'b1;
                extop    = EXT_UPPER;
                memtoreg = M2R_EXIMM;
            end
            OP_LW: begin
                iclass   = CLS_LW;
                legal    = 1'b1;
                alusrc   = 1'b1;
                extop    = EXT_SIGN;
                memtoreg = M2R_DOUT;
            end
            OP_SW: begin
                iclass = CLS_SW;
                legal  = 1'b1;
                alusrc = 1'b1;
                extop  = EXT_SIGN;
            end
            OP_BEQ: begin
                iclass = CLS_BEQ;
                legal  = 1'b1;
                extop  = EXT_SIGN;
                aluctr = ALU_SUB;
            end
            OP_J: begin
                iclass = CLS_J;
                legal  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencing controller. Steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, gates PC/RF/DM writes per state, waits on a
// DM handshake with timeout, counts retired instructions and halts on
// illegal instructions or memory timeouts.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             pc_we,
    output logic             ir_we,
    output logic             RegWrite,
    output logic             ALUsrc,
    output logic             RegDst,
    output logic             MemWrite,
    output logic [1:0]       MemToReg,
    output logic [1:0]       npcctrol,
    output logic [1:0]       ExtOp,
    output logic [2:0]       ALUctr,
    output logic             mem_req,
    output logic [2:0]       state,
    output logic             halt,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t              state_reg;
    logic                halt_reg;
    logic                err_reg;
    logic [WAIT_W-1:0]   wait_reg;
    logic [CNT_W-1:0]    cnt_reg;

    iclass_t             dec_class;
    logic                dec_legal;
    logic                dec_alusrc;
    logic                dec_regdst;
    logic [1:0]          dec_extop;
    logic [1:0]          dec_memtoreg;
    logic [2:0]          dec_aluctr;
    logic                in_flight;

    mc_decode u_decode (
        .op       (op),
        .func     (func),
        .iclass   (dec_class),
        .legal    (dec_legal),
        .alusrc   (dec_alusrc),
        .regdst   (dec_regdst),
        .extop    (dec_extop),
        .memtoreg (dec_memtoreg),
        .aluctr   (dec_aluctr)
    );

    assign in_flight = (state_reg == ST_DECODE) || (state_reg == ST_EXEC) ||
                       (state_reg == ST_MEM)    || (state_reg == ST_WB);

    // Per-state strobes and held static controls; everything is 0 while clr is low
    always_comb begin
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        mem_req  = 1'b0;
        npcctrol = NPC_SEQ;
        ALUsrc   = 1'b0;
        RegDst   = 1'b0;
        ExtOp    = EXT_ZERO;
        ALUctr   = ALU_ADD;
        MemToReg = M2R_ALU;
        if (clr) begin
            case (state_reg)
                ST_FETCH:  ir_we = run;
                ST_DECODE: begin
                    if (dec_legal && (dec_class == CLS_J)) begin
                        pc_we    = 1'b1;
                        npcctrol = NPC_JUMP;
                    end
                end
                ST_EXEC: begin
                    if (dec_class == CLS_BEQ) begin
                        pc_we    = 1'b1;
                        npcctrol = zero ? NPC_BRANCH : NPC_SEQ;
                    end
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    MemWrite = (dec_class == CLS_SW);
                    if (mem_ack && (dec_class == CLS_SW)) begin
                        pc_we = 1'b1;
                    end
                end
                ST_WB: begin
                    RegWrite = 1'b1;
                    pc_we    = 1'b1;
                end
                default: ;
            endcase
            if (in_flight) begin
                ALUsrc   = dec_alusrc;
                RegDst   = dec_regdst;
                ExtOp    = dec_extop;
                ALUctr   = dec_aluctr;
                MemToReg = dec_memtoreg;
            end
        end
    end

    // Sequencer, memory wait counter, sticky halt/err and retire counter
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg <= ST_FETCH;
            halt_reg  <= 1'b0;
            err_reg   <= 1'b0;
            wait_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (run) state_reg <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (!dec_legal) begin
                        state_reg <= ST_HALT;
                        halt_reg  <= 1'b1;
                    end else if (dec_class == CLS_J) begin
                        state_reg <= ST_FETCH;
                    end else begin
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (dec_class == CLS_BEQ) begin
                        state_reg <= ST_FETCH;
                    end else if ((dec_class == CLS_LW) || (dec_class == CLS_SW)) begin
                        state_reg <= ST_MEM;
                        wait_reg  <= '0;
                    end else begin
                        state_reg <= ST_WB;
                    end
                end
                ST_MEM: begin
                    // An acknowledge on the final allowed cycle still completes the access
                    if (mem_ack) begin
                        state_reg <= (dec_class == CLS_LW) ? ST_WB : ST_FETCH;
                    end else if (wait_reg == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_reg <= ST_HALT;
                        halt_reg  <= 1'b1;
                        err_reg   <= 1'b1;
                    end else begin
                        wait_reg <= wait_reg + WAIT_W'(1);
                    end
                end
                ST_WB:   state_reg <= ST_FETCH;
                ST_HALT: state_reg <= ST_HALT;
                default: begin
                    state_reg <= ST_HALT;
                    halt_reg  <= 1'b1;
                end
            endcase
            if (pc_we) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign state     = state_reg;
    assign halt      = halt_reg;
    assign err       = err_reg;
    assign instr_cnt = cnt_reg;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl: one task per scenario, inline checks.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        run;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        zero;
    logic        mem_ack;
    logic        pc_we, ir_we, RegWrite, ALUsrc, RegDst, MemWrite, mem_req, halt, err;
    logic [1:0]  MemToReg, npcctrol, ExtOp;
    logic [2:0]  ALUctr, state;
    logic [31:0] instr_cnt;

    int tests = 0;
    int fails = 0;

    // {state, pc_we, ir_we, RegWrite, mem_req, MemWrite}
    logic [7:0]  strobes;
    logic [52:0] all_out;
    assign strobes = {state, pc_we, ir_we, RegWrite, mem_req, MemWrite};
    assign all_out = {pc_we, ir_we, RegWrite, ALUsrc, RegDst, MemWrite, MemToReg, npcctrol,
                      ExtOp, ALUctr, mem_req, state, halt, err, instr_cnt};

    always #5 clk = ~clk;

    mc_ctrl #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
        .clk(clk), .clr(clr), .run(run), .op(op), .func(func), .zero(zero),
        .mem_ack(mem_ack), .pc_we(pc_we), .ir_we(ir_we), .RegWrite(RegWrite),
        .ALUsrc(ALUsrc), .RegDst(RegDst), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .npcctrol(npcctrol), .ExtOp(ExtOp), .ALUctr(ALUctr), .mem_req(mem_req),
        .state(state), .halt(halt), .err(err), .instr_cnt(instr_cnt)
    );

    // Drive one instruction for ncyc cycles without checking (setup only)
    task automatic run_plain(input logic [5:0] o, input logic [5:0] f, input int ncyc);
        op = o; func = f; run = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            run = 1'b0;
        end
    endtask

    task automatic test_reset();
        clr = 1'b0; run = 1'b1; op = 6'b000000; func = 6'b100000; zero = 1'b0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (all_out !== '0) begin
            fails++; $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        run = 1'b0; clr = 1'b1;
        @(negedge clk);
        tests++;
        if (strobes !== 8'h00 || instr_cnt !== 32'd0) begin
            fails++; $display("FAIL reset_release: strobes=%b cnt=%0d expected 00000000 cnt=0", strobes, instr_cnt);
        end
        @(posedge clk); #1;
        $display("[TB] reset done");
    endtask

    task automatic test_add();
        logic [7:0] exp_s [5];
        exp_s = '{{3'd0,5'b01000}, {3'd1,5'b00000}, {3'd2,5'b00000}, {3'd4,5'b10100}, {3'd0,5'b00000}};
        op = 6'b000000; func = 6'b100000; run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (strobes !== exp_s[i]) begin
                fails++; $display("FAIL add_cyc%0d: strobes=%b expected %b", i, strobes, exp_s[i]);
            end
            if (i == 3) begin
                tests++;
                if ({RegDst, ALUsrc, MemToReg, ALUctr} !== 7'b1_0_00_000) begin
                    fails++; $display("FAIL add_static: got %b expected 1000000", {RegDst, ALUsrc, MemToReg, ALUctr});
                end
            end
            @(posedge clk); #1;
            run = 1'b0;
        end
        tests++;
        if (instr_cnt !== 32'd1) begin
            fails++; $display("FAIL add_cnt: got %0d expected 1", instr_cnt);
        end
        $display("[TB] add done cnt=%0d", instr_cnt);
    endtask

    task automatic test_lw_wait();
        logic [7:0] exp_s [8];
        exp_s = '{{3'd0,5'b01000}, {3'd1,5'b00000}, {3'd2,5'b00000}, {3'd3,5'b00010},
                  {3'd3,5'b00010}, {3'd3,5'b00010}, {3'd4,5'b10100}, {3'd0,5'b00000}};
        op = 6'b100011; func = 6'b000000; run = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests++;
            if (strobes !== exp_s[i]) begin
                fails++; $display("FAIL lw_cyc%0d: strobes=%b expected %b", i, strobes, exp_s[i]);
            end
            if (i == 6) begin
                tests++;
                if ({MemToReg, ALUsrc, ExtOp, MemWrite} !== 6'b01_1_01_0) begin
                    fails++; $display("FAIL lw_wb_ctrl: got %b expected 011010", {MemToReg, ALUsrc, ExtOp, MemWrite});
                end
            end
            @(posedge clk); #1;
            run = 1'b0;
            mem_ack = (i == 4);
        end
        tests++;
        if (instr_cnt !== 32'd2) begin
            fails++; $display("FAIL lw_cnt: got %0d expected 2", instr_cnt);
        end
        $display("[TB] lw with wait done cnt=%0d", instr_cnt);
    endtask

    task automatic test_beq();
        logic [7:0] exp_s [3];
        exp_s = '{{3'd0,5'b01000}, {3'd1,5'b00000}, {3'd2,5'b10000}};
        for (int k = 0; k < 2; k++) begin
            op = 6'b000100; func = 6'b000000; zero = (k == 0); run = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                tests++;
                if (strobes !== exp_s[i]) begin
                    fails++; $display("FAIL beq%0d_cyc%0d: strobes=%b expected %b", k, i, strobes, exp_s[i]);
                end
                if (i == 2) begin
                    tests++;
                    if ({npcctrol, ALUctr} !== ((k == 0) ? 5'b01_001 : 5'b00_001)) begin
                        fails++; $display("FAIL beq%0d_npc: got %b expected %b", k, {npcctrol, ALUctr},
                                          (k == 0) ? 5'b01_001 : 5'b00_001);
                    end
                end
                @(posedge clk); #1;
                run = 1'b0;
            end
        end
        zero = 1'b0;
        tests++;
        if (state !== 3'd0 || instr_cnt !== 32'd4) begin
            fails++; $display("FAIL beq_end: state=%0d cnt=%0d expected 0 4", state, instr_cnt);
        end
        $display("[TB] beq taken/not-taken done cnt=%0d", instr_cnt);
    endtask

    task automatic test_jump_sw();
        // j: FETCH, DECODE(retire)
        op = 6'b000010; func = 6'b000000; run = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        run = 1'b0;
        @(negedge clk);
        tests++;
        if ({strobes, npcctrol} !== {3'd1, 5'b10000, 2'b10}) begin
            fails++; $display("FAIL j_decode: got %b expected 0011000010", {strobes, npcctrol});
        end
        @(posedge clk); #1;
        // sw with immediate acknowledge: 4 cycles
        op = 6'b101011; run = 1'b1; mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) begin
                tests++;
                if ({ALUsrc, ExtOp, RegDst} !== 4'b1_01_0) begin
                    fails++; $display("FAIL sw_static: got %b expected 1010", {ALUsrc, ExtOp, RegDst});
                end
            end
            if (i == 3) begin
                tests++;
                if (strobes !== {3'd3, 5'b10011}) begin
                    fails++; $display("FAIL sw_mem: strobes=%b expected 01110011", strobes);
                end
            end
            @(posedge clk); #1;
            run = 1'b0;
        end
        mem_ack = 1'b0;
        tests++;
        if (state !== 3'd0 || instr_cnt !== 32'd6) begin
            fails++; $display("FAIL jsw_end: state=%0d cnt=%0d expected 0 6", state, instr_cnt);
        end
        $display("[TB] j and sw done cnt=%0d", instr_cnt);
    endtask

    task automatic test_imm();
        logic [5:0] ops [3];
        logic [5:0] exp_c [3];  // {ALUsrc, ExtOp, MemToReg, RegDst}
        ops   = '{6'b001101, 6'b001001, 6'b001111};
        exp_c = '{6'b1_00_00_0, 6'b1_01_00_0, 6'b1_10_10_0};
        for (int k = 0; k < 3; k++) begin
            op = ops[k]; func = 6'b000000; run = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (i == 3) begin
                    tests++;
                    if ({strobes, ALUsrc, ExtOp, MemToReg, RegDst} !== {3'd4, 5'b10100, exp_c[k]}) begin
                        fails++; $display("FAIL imm%0d_wb: got %b expected %b", k,
                                          {strobes, ALUsrc, ExtOp, MemToReg, RegDst}, {3'd4, 5'b10100, exp_c[k]});
                    end
                    if (k == 0) begin
                        tests++;
                        if (ALUctr !== 3'b011) begin
                            fails++; $display("FAIL ori_aluctr: got %b expected 011", ALUctr);
                        end
                    end
                end
                @(posedge clk); #1;
                run = 1'b0;
            end
        end
        tests++;
        if (instr_cnt !== 32'd9) begin
            fails++; $display("FAIL imm_cnt: got %0d expected 9", instr_cnt);
        end
        $display("[TB] ori/addiu/lui done cnt=%0d", instr_cnt);
    endtask

    task automatic test_ack_on_timeout_cycle();
        logic [7:0] e;
        op = 6'b101011; func = 6'b000000; run = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 19; i++) begin
            e = (i == 0) ? {3'd0, 5'b01000} : (i == 1) ? {3'd1, 5'b00000} : (i == 2) ? {3'd2, 5'b00000} :
                (i < 17) ? {3'd3, 5'b00011} : (i == 17) ? {3'd3, 5'b10011} : {3'd0, 5'b00000};
            @(negedge clk);
            tests++;
            if (strobes !== e) begin
                fails++; $display("FAIL ack_last_cyc%0d: strobes=%b expected %b", i, strobes, e);
            end
            @(posedge clk); #1;
            run = 1'b0;
            mem_ack = (i == 16);
        end
        tests++;
        if ({halt, err} !== 2'b00 || instr_cnt !== 32'd10) begin
            fails++; $display("FAIL ack_last_end: halt=%b err=%b cnt=%0d expected 0 0 10", halt, err, instr_cnt);
        end
        $display("[TB] ack on final MEM cycle done cnt=%0d", instr_cnt);
    endtask

    task automatic test_timeout();
        logic [7:0] e;
        op = 6'b101011; func = 6'b000000; run = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            e = (i == 0) ? {3'd0, 5'b01000} : (i == 1) ? {3'd1, 5'b00000} : (i == 2) ? {3'd2, 5'b00000} :
                (i < 18) ? {3'd3, 5'b00011} : {3'd7, 5'b00000};
            @(negedge clk);
            tests++;
            if (strobes !== e) begin
                fails++; $display("FAIL timeout_cyc%0d: strobes=%b expected %b", i, strobes, e);
            end
            @(posedge clk); #1;
            run = 1'b0;
        end
        tests++;
        if ({halt, err} !== 2'b11 || instr_cnt !== 32'd10) begin
            fails++; $display("FAIL timeout_halt: halt=%b err=%b cnt=%0d expected 1 1 10", halt, err, instr_cnt);
        end
        clr = 1'b0;
        #1;
        tests++;
        if (all_out !== '0) begin
            fails++; $display("FAIL timeout_clr: got %h expected 0", all_out);
        end
        @(posedge clk); #1;
        clr = 1'b1;
        $display("[TB] mem timeout halt done");
    endtask

    task automatic test_illegal();
        logic [5:0] ops [2];
        logic [5:0] fns [2];
        ops = '{6'b111111, 6'b000000};
        fns = '{6'b100000, 6'b000000};
        for (int k = 0; k < 2; k++) begin
            run_plain(6'b000000, 6'b100000, 4);
            tests++;
            if (instr_cnt !== 32'd1) begin
                fails++; $display("FAIL ill%0d_pre_cnt: got %0d expected 1", k, instr_cnt);
            end
            op = ops[k]; func = fns[k]; run = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                tests++;
                if ({strobes, halt, err} !== ((i == 0) ? {3'd0, 5'b01000, 2'b00} : (i == 1) ? {3'd1, 5'b00000, 2'b00}
                                                      : {3'd7, 5'b00000, 2'b10})) begin
                    fails++; $display("FAIL ill%0d_cyc%0d: got %b", k, i, {strobes, halt, err});
                end
                @(posedge clk); #1;
                run = (i != 0);
            end
            run = 1'b0;
            clr = 1'b0;
            #1;
            tests++;
            if (state !== 3'd0 || instr_cnt !== 32'd0 || halt !== 1'b0) begin
                fails++; $display("FAIL ill%0d_clr: state=%0d cnt=%0d halt=%b expected 0 0 0", k, state, instr_cnt, halt);
            end
            @(posedge clk); #1;
            clr = 1'b1;
        end
        $display("[TB] illegal op and illegal func done");
    endtask

    task automatic test_reset_mid_mem();
        run_plain(6'b000000, 6'b100000, 4);
        op = 6'b101011; func = 6'b000000; run = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            run = 1'b0;
        end
        #1;
        tests++;
        if (strobes !== {3'd3, 5'b00011} || instr_cnt !== 32'd1) begin
            fails++; $display("FAIL midrst_pre: strobes=%b cnt=%0d expected 01100011 1", strobes, instr_cnt);
        end
        clr = 1'b0;
        #1;
        tests++;
        if (all_out !== '0) begin
            fails++; $display("FAIL midrst_clr: got %h expected 0", all_out);
        end
        @(posedge clk); #1;
        clr = 1'b1;
        op = 6'b000000; func = 6'b100000; run = 1'b1;
        @(negedge clk);
        tests++;
        if (strobes !== {3'd0, 5'b01000}) begin
            fails++; $display("FAIL midrst_restart: strobes=%b expected 00001000", strobes);
        end
        @(posedge clk); #1;
        run = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (state !== 3'd0 || instr_cnt !== 32'd1) begin
            fails++; $display("FAIL midrst_after: state=%0d cnt=%0d expected 0 1", state, instr_cnt);
        end
        $display("[TB] reset during MEM done cnt=%0d", instr_cnt);
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_beq();
        test_jump_sw();
        test_imm();
        test_ack_on_timeout_cycle();
        test_timeout();
        test_illegal();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
